pmod_dac_arbiter: RTL and testbench

//  Shares one pmod_dac_block between NUM_REQ on-chip requesters.
//  - Round-robin arbitration; sequences load_din/start into the DAC block.
//  - Detects transfer completion by watching the DAC's dac_cs_n/dac_ldac_n pins.
//  - Acks the granted requester; a timeout guard recovers from a stalled DAC.
//  - Sits between the SoC register/stream logic and pmod_dac_block, in the clk domain.

---
 rtl/pmod_dac_arbiter_if.sv | 31 +++
 rtl/pmod_dac_arbiter.sv | 143 ++++++++++++++
 tb/tb_pmod_dac_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmod_dac_arbiter_if.sv
// Bundle between the on-chip requesters, the arbiter and the pmod_dac_block pins.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface pmod_dac_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned RESOLUTION = 16
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*RESOLUTION-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic [IDW-1:0]                grant_id;
  logic                          busy;
  logic                          timeout_err;
  logic                          err_clr;
  logic [RESOLUTION-1:0]         dac_din;
  logic                          dac_load;
  logic                          dac_start;
  logic                          dac_cs_n;
  logic                          dac_ldac_n;

  modport master (
    output req, req_data, err_clr, dac_cs_n, dac_ldac_n,
    input  ack, grant_id, busy, timeout_err, dac_din, dac_load, dac_start
  );

  modport slave (
    input  req, req_data, err_clr, dac_cs_n, dac_ldac_n,
    output ack, grant_id, busy, timeout_err, dac_din, dac_load, dac_start
  );
endinterface

// File: rtl/pmod_dac_arbiter.sv
// Round-robin arbiter that shares one pmod_dac_block among NUM_REQ requesters,
// sequencing load/start and detecting completion from the DAC's cs_n/ldac_n pins.
module pmod_dac_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned RESOLUTION = 16,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pmod_dac_arbiter_if.slave      bus
);
  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_LDAC, S_WAIT_DONE, S_ACK
  } state_e;

  state_e                state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [IDW-1:0]        grant_q, grant_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [RESOLUTION-1:0] din_q, din_d;
  logic                  load_q, load_d;
  logic                  start_q, start_d;
  logic [1:0]            cs_sync_q, ldac_sync_q;

  logic                  cs_s, ldac_s;
  logic                  win_found;
  logic [IDW-1:0]        win_idx;
  logic [IDW-1:0]        cand;
  logic [RESOLUTION-1:0] words [NUM_REQ];

  assign cs_s   = cs_sync_q[1];
  assign ldac_s = ldac_sync_q[1];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = bus.req_data[g*RESOLUTION +: RESOLUTION];
  end

  // First set request after the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    err_d   = err_q & ~bus.err_clr;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          din_d   = words[win_idx];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_START;
      end
      S_START, S_WAIT_LDAC, S_WAIT_DONE: begin
        cnt_d = cnt_q + CW'(1);
        // Stalled DAC: abandon the transfer, requester goes to the back of the queue.
        if (cnt_q == CW'(TIMEOUT - 2)) begin
          state_d = S_IDLE;
          ptr_d   = grant_q;
          err_d   = 1'b1;
        end else begin
          case (state_q)
            S_START:     if (!cs_s)   state_d = S_WAIT_LDAC;
            S_WAIT_LDAC: if (!ldac_s) state_d = S_WAIT_DONE;
            default:     if (ldac_s)  state_d = S_ACK;
          endcase
        end
      end
      S_ACK: begin
        ptr_d   = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    load_d  = (state_d == S_LOAD);
    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
    ack_d   = (state_d == S_ACK) ? (NUM_REQ'(1) << grant_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDW'(NUM_REQ - 1);
      grant_q     <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      din_q       <= '0;
      load_q      <= 1'b0;
      start_q     <= 1'b0;
      cs_sync_q   <= '1;
      ldac_sync_q <= '1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      din_q       <= din_d;
      load_q      <= load_d;
      start_q     <= start_d;
      cs_sync_q   <= {cs_sync_q[0], bus.dac_cs_n};
      ldac_sync_q <= {ldac_sync_q[0], bus.dac_ldac_n};
    end
  end

  assign bus.ack         = ack_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;
  assign bus.dac_din     = din_q;
  assign bus.dac_load    = load_q;
  assign bus.dac_start   = start_q;
endmodule

// File: tb/tb_pmod_dac_arbiter.sv
// Scoreboard bench for pmod_dac_arbiter: expected grants are queued from a
// rotate-and-scan arbitration model; a monitor checks loads and acks as they appear.
module tb_pmod_dac_arbiter;
  localparam int unsigned NR  = 4;
  localparam int unsigned RES = 16;
  localparam int unsigned TO  = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pmod_dac_arbiter_if #(.NUM_REQ(NR), .RESOLUTION(RES)) bus ();

  pmod_dac_arbiter #(.NUM_REQ(NR), .RESOLUTION(RES), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int             id;
    logic [RES-1:0] word;
    bit             stall;
  } exp_t;

  exp_t           exp_q[$];
  exp_t           mon_e;
  int             n_checks = 0;
  int             n_fail   = 0;
  int             ptr_m    = NR - 1;
  logic [RES-1:0] words_m [NR];
  bit             stall_mode   = 1'b0;
  bit             slow_ldac    = 1'b0;
  bit             model_active = 1'b0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void flag_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not allowed at %0t", nm, $time);
  endfunction

  // Reference arbitration: rotate the request vector so the slot after the
  // last grantee sits at bit 0, then take the lowest set bit.
  function automatic int ref_grant(input logic [NR-1:0] r, input int p);
    logic [2*NR-1:0] dbl;
    logic [NR-1:0]   rot;
    dbl = {r, r};
    rot = NR'(dbl >> (p + 1));
    for (int j = 0; j < int'(NR); j++)
      if (rot[j]) return (p + 1 + j) % int'(NR);
    return -1;
  endfunction

  task automatic load_words();
    for (int i = 0; i < int'(NR); i++) bus.req_data[i*RES +: RES] = words_m[i];
  endtask

  task automatic rand_words();
    for (int i = 0; i < int'(NR); i++) words_m[i] = RES'($urandom);
    load_words();
  endtask

  task automatic check_reset_vals();
    check("rst_ack",         32'(bus.ack),         32'(0));
    check("rst_grant_id",    32'(bus.grant_id),    32'(0));
    check("rst_busy",        32'(bus.busy),        32'(0));
    check("rst_timeout_err", 32'(bus.timeout_err), 32'(0));
    check("rst_dac_din",     32'(bus.dac_din),     32'(0));
    check("rst_dac_load",    32'(bus.dac_load),    32'(0));
    check("rst_dac_start",   32'(bus.dac_start),   32'(0));
  endtask

  // Hold r until n acks have been seen, then drop it on the cycle after the last ack.
  task automatic run_phase(input logic [NR-1:0] r, input int n);
    int g, got, cyc;
    for (int i = 0; i < n; i++) begin
      g = ref_grant(r, ptr_m);
      exp_q.push_back('{g, words_m[g], 1'b0});
      ptr_m = g;
    end
    @(negedge clk);
    bus.req = r;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != '0) got++;
    end
    bus.req = '0;
    if (got < n) begin
      flag_fail("phase_ack_wait");
      exp_q.delete();
    end
  endtask

  // DAC never answers; the transfer must be abandoned after TO-1 start cycles.
  task automatic run_stall(input logic [NR-1:0] r, input bit hold_clr);
    int g, cnt, cyc;
    g = ref_grant(r, ptr_m);
    exp_q.push_back('{g, words_m[g], 1'b1});
    stall_mode = 1'b1;
    @(negedge clk);
    bus.req     = r;
    bus.err_clr = hold_clr;
    cnt = 0;
    cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.dac_start) cnt++;
      else if (cnt > 0) break;
    end
    check("start_high_cycles",  32'(cnt),             32'(TO - 1));
    check("timeout_err_set",    32'(bus.timeout_err), 32'(1));
    check("busy_after_timeout", 32'(bus.busy),        32'(0));
    check("ack_at_timeout",     32'(bus.ack),         32'(0));
    bus.req     = '0;
    bus.err_clr = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    ptr_m      = g;
    stall_mode = 1'b0;
    @(negedge clk);
    check("timeout_err_sticky", 32'(bus.timeout_err), 32'(1));
  endtask

  // Behavioural DAC: after start, cs_n low, then cs_n high with ldac_n low, then ldac_n high.
  initial begin
    bus.dac_cs_n   = 1'b1;
    bus.dac_ldac_n = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.dac_start && !stall_mode) begin
        model_active = 1'b1;
        repeat ($urandom_range(2, 5)) @(negedge clk);
        bus.dac_cs_n = 1'b0;
        repeat ($urandom_range(2, 5)) @(negedge clk);
        bus.dac_cs_n   = 1'b1;
        bus.dac_ldac_n = 1'b0;
        repeat (slow_ldac ? 20 : $urandom_range(2, 5)) @(negedge clk);
        bus.dac_ldac_n = 1'b1;
        model_active   = 1'b0;
      end
    end
  end

  // Monitor: compare every load and ack against the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.dac_load) begin
        if (exp_q.size() == 0) flag_fail("load_unexpected");
        else begin
          check("load_grant_id", 32'(bus.grant_id), 32'(exp_q[0].id));
          check("load_din",      32'(bus.dac_din),  32'(exp_q[0].word));
        end
      end
      if (bus.ack != '0) begin
        if (exp_q.size() == 0) flag_fail("ack_unexpected");
        else if (exp_q[0].stall) flag_fail("ack_on_timeout");
        else begin
          mon_e = exp_q.pop_front();
          check("ack_vector", 32'(bus.ack), 32'(1) << mon_e.id);
        end
      end
      if ($countones(bus.ack) > 1) flag_fail("ack_not_onehot");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [NR-1:0] r;
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.err_clr = 1'b0;
    for (int i = 0; i < int'(NR); i++) words_m[i] = '0;
    load_words();
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    // Fairness from reset: 0,1,2,3,0,1,2,3
    rand_words();
    run_phase(4'b1111, 8);

    // Single request with latency checks
    words_m[0] = 16'hA5C3;
    load_words();
    exp_q.push_back('{ref_grant(4'b0001, ptr_m), words_m[0], 1'b0});
    ptr_m = ref_grant(4'b0001, ptr_m);
    @(negedge clk);
    bus.req = 4'b0001;
    @(negedge clk);
    check("load_latency",    32'(bus.dac_load),  32'(1));
    check("start_not_yet",   32'(bus.dac_start), 32'(0));
    @(negedge clk);
    check("start_latency",   32'(bus.dac_start), 32'(1));
    cyc = 0;
    while (bus.ack == '0 && cyc < 200) begin @(negedge clk); cyc++; end
    bus.req = '0;
    check("single_ack_seen", 32'(bus.ack), 32'(4'b0001));
    @(negedge clk);
    check("single_busy_low", 32'(bus.busy), 32'(0));

    // Wrap and skip: grant 2, then 0 and 1 with requester 3 idle
    rand_words();
    run_phase(4'b0100, 1);
    run_phase(4'b0011, 2);

    // Randomized phases
    for (int p = 0; p < 12; p++) begin
      rand_words();
      r = NR'($urandom_range(1, 15));
      run_phase(r, int'($urandom_range(1, 5)));
    end

    // Timeout, then clear the sticky flag
    rand_words();
    run_stall(4'b0001, 1'b0);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("err_clr_clears", 32'(bus.timeout_err), 32'(0));

    // Timeout coinciding with err_clr: set wins
    run_stall(4'b0011, 1'b1);

    // Reset while waiting for ldac_n to return high
    slow_ldac  = 1'b1;
    words_m[3] = 16'h1234;
    load_words();
    exp_q.push_back('{ref_grant(4'b1000, ptr_m), words_m[3], 1'b0});
    @(negedge clk);
    bus.req = 4'b1000;
    cyc = 0;
    while (bus.dac_ldac_n && cyc < 200) begin @(negedge clk); cyc++; end
    repeat (5) @(negedge clk);
    check("pre_reset_busy",  32'(bus.busy),      32'(1));
    check("pre_reset_start", 32'(bus.dac_start), 32'(0));
    rst_n   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    check_reset_vals();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    rst_n     = 1'b1;
    ptr_m     = NR - 1;
    slow_ldac = 1'b0;
    cyc = 0;
    while (model_active && cyc < 200) begin @(negedge clk); cyc++; end
    rand_words();
    run_phase(4'b0100, 1);
    check("post_reset_grant", 32'(bus.grant_id), 32'(2));

    repeat (5) @(negedge clk);
    check("final_busy",  32'(bus.busy),     32'(0));
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
